bitwise16_arbiter: RTL and testbench

Round-robin controller that shares one 16-bit bitwise AND datapath (the `And16` gate array) among several requesters. It accepts one request at a time, drives the shared datapath, and returns the result on a single valid/ready response port tagged with the requester index. It sits between the CPU-side logic clients and the gate-level bitwise unit. AND, NAND, OR and NOR are all derived from the single AND array using input and output inversion (De Morgan).

---
 rtl/bitwise16_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bitwise16_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise16_arbiter.sv
// bitwise16_arbiter: round-robin front end that shares one 16-bit AND array
// among NREQ requesters. AND/NAND/OR/NOR are built from that single array via
// input/output inversion. The response is tagged with the requester index.
// Optional build macro: BITWISE16_ARB_BYPASS_EN removes the EXEC state. The
// result is then computed from the granted inputs in IDLE, which gives a
// latency of 1 cycle.
module bitwise16_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [16*NREQ-1:0]  req_a,
    input  logic [16*NREQ-1:0]  req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_data,
    output logic                busy
);

`ifdef BITWISE16_ARB_BYPASS_EN
    typedef enum logic [1:0] {IDLE, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
`endif

    state_t         state_q;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] id_q;
    logic [15:0]    data_q;
`ifndef BITWISE16_ARB_BYPASS_EN
    logic [1:0]     op_q;
    logic [15:0]    a_q;
    logic [15:0]    b_q;
`endif

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [1:0]     gnt_op;
    logic [15:0]    gnt_a;
    logic [15:0]    gnt_b;
    logic [15:0]    data_d;

    // Shared And16 array: OR/NOR invert the inputs (De Morgan).
    // NAND/OR invert the output.
    function automatic logic [15:0] and16_op(input logic [1:0]  op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] and_out;
        x       = op[1] ? ~a : a;
        y       = op[1] ? ~b : b;
        and_out = x & y;
        return (op == 2'b01 || op == 2'b10) ? ~and_out : and_out;
    endfunction

    // Round-robin pick. Prefer the first valid requester above last_grant_q.
    // Otherwise wrap around to the first valid requester at or below it.
    always_comb begin
        logic           found_hi;
        logic           found_lo;
        logic [IDW-1:0] idx_hi;
        logic [IDW-1:0] idx_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (req_valid[j]) begin
                if (IDW'(j) > last_grant_q) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = IDW'(j);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = IDW'(j);
                end
            end
        end
        gnt_found = found_hi | found_lo;
        gnt_idx   = found_hi ? idx_hi : idx_lo;
    end

    // Select the op and operands of the granted requester.
    always_comb begin
        gnt_op = '0;
        gnt_a  = '0;
        gnt_b  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gnt_idx == IDW'(j)) begin
                gnt_op = req_op[2*j +: 2];
                gnt_a  = req_a[16*j +: 16];
                gnt_b  = req_b[16*j +: 16];
            end
        end
    end

    // Single use of the shared array. The source depends on the build.
    always_comb begin
`ifdef BITWISE16_ARB_BYPASS_EN
        data_d = and16_op(gnt_op, gnt_a, gnt_b);
`else
        data_d = and16_op(op_q, a_q, b_q);
`endif
    end

    // Accept strobe: one-hot on the granted index, only in IDLE, never under reset.
    always_comb begin
        req_ready = '0;
        if (reset_n && state_q == IDLE && gnt_found) begin
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (gnt_idx == IDW'(j)) begin
                    req_ready[j] = 1'b1;
                end
            end
        end
    end

    // Control FSM: accept in IDLE, compute, then hold the response until it is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            data_q       <= '0;
`ifndef BITWISE16_ARB_BYPASS_EN
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_found) begin
                        last_grant_q <= gnt_idx;
                        id_q         <= gnt_idx;
`ifdef BITWISE16_ARB_BYPASS_EN
                        data_q       <= data_d;
                        state_q      <= RESP;
`else
                        op_q         <= gnt_op;
                        a_q          <= gnt_a;
                        b_q          <= gnt_b;
                        state_q      <= EXEC;
`endif
                    end
                end
`ifndef BITWISE16_ARB_BYPASS_EN
                EXEC: begin
                    data_q  <= data_d;
                    state_q <= RESP;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_bitwise16_arbiter.sv
// tb_bitwise16_arbiter: directed self-checking bench for bitwise16_arbiter.
// Honours BITWISE16_ARB_BYPASS_EN for the expected latency.
module tb_bitwise16_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef BITWISE16_ARB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_op;
    logic [16*NREQ-1:0]  req_a;
    logic [16*NREQ-1:0]  req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_data;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitwise16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_op[2*idx +: 2]  = op;
        req_a[16*idx +: 16] = a;
        req_b[16*idx +: 16] = b;
        req_valid[idx]      = 1'b1;
    endtask

    // Wait (bounded) for any accept strobe, then check that it is the expected one-hot.
    task automatic wait_grant(input int idx, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_grant"}, 32'(req_ready), 32'(1 << idx));
    endtask

    // Accept edge, drop valid, wait for the response, check it, and consume it.
    task automatic finish_op(input int idx, input logic [15:0] exp_data, input string tag);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        req_valid[idx] = 1'b0;
        @(negedge clk);
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_lat"}, 32'(k + 1), 32'(LAT));
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(idx));
        check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] b_f   [4];
        logic [15:0] exp_f [4];
        int          order [6];
        int          last_cyc;
        int          n;
        int          cnt;

        b_f   = '{16'h00A5, 16'h10A5, 16'h20A5, 16'h30A5};
        exp_f = '{16'h00A0, 16'h10A0, 16'h20A0, 16'h30A0};
        order = '{0, 1, 2, 3, 0, 1};
        last_cyc = 0;

        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        check_eq("rst_outputs", {9'b0, rsp_valid, busy, rsp_id, rsp_data, req_ready}, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("idle_quiet", {27'b0, busy, req_ready}, 32'h0);
        end
        @(posedge clk);
        #1;

        // Single request from requester 2.
        set_req(2, 2'b00, 16'hF0F0, 16'hFF00);
        wait_grant(2, "single");
        finish_op(2, 16'hF000, "single");

        // Op coverage through requester 0.
        set_req(0, 2'b01, 16'h00FF, 16'h0F0F);
        wait_grant(0, "nand");
        finish_op(0, 16'hFFF0, "nand");
        set_req(0, 2'b10, 16'h00FF, 16'h0F0F);
        wait_grant(0, "or");
        finish_op(0, 16'h0FFF, "or");
        set_req(0, 2'b11, 16'h00FF, 16'h0F0F);
        wait_grant(0, "nor");
        finish_op(0, 16'hF000, "nor");
        set_req(0, 2'b00, 16'h00FF, 16'h0F0F);
        wait_grant(0, "and");
        finish_op(0, 16'h000F, "and");

        // Fairness: reset restores requester 0 priority, all four continuously valid.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 16'hFFF0, b_f[i]);
        for (int g = 0; g < 6; g++) begin
            wait_grant(order[g], "fair");
            if (g > 0) check_eq("fair_gap", 32'(cyc - last_cyc), 32'(LAT + 1));
            last_cyc = cyc;
            @(posedge clk);
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check_eq("fair_id", 32'(rsp_id), 32'(order[g]));
            check_eq("fair_data", 32'(rsp_data), 32'(exp_f[order[g]]));
        end
        req_valid = '0;
        @(posedge clk);
        #1;

        // Requester 3, then requester 1 alone.
        set_req(3, 2'b11, 16'h0000, 16'h8001);
        wait_grant(3, "r3");
        finish_op(3, 16'h7FFE, "r3");
        set_req(1, 2'b01, 16'hFFFF, 16'h00FF);
        wait_grant(1, "r1");
        finish_op(1, 16'hFF00, "r1");

        // Backpressure in RESP with another requester waiting.
        rsp_ready = 1'b0;
        set_req(2, 2'b10, 16'h1234, 16'h00F0);
        wait_grant(2, "bp");
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        set_req(3, 2'b00, 16'hFFFF, 16'h5A5A);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            check_eq("bp_exec_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check_eq("bp_hold", {9'b0, rsp_valid, rsp_id, rsp_data, req_ready},
                     {9'b0, 1'b1, 2'd2, 16'h12F4, 4'b0000});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_release", {27'b0, rsp_valid, req_ready}, {27'b0, 1'b0, 4'b1000});
        finish_op(3, 16'h5A5A, "bp_next");

        // Reset during EXEC: no response, requester 0 first afterwards.
        set_req(1, 2'b01, 16'h00FF, 16'h0F0F);
        wait_grant(1, "mid");
        @(posedge clk);
        #1;
        req_valid = '0;
        reset_n   = 1'b0;
        #1;
        check_eq("mid_rst_outputs", {9'b0, rsp_valid, busy, rsp_id, rsp_data, req_ready}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        check_eq("mid_no_rsp", 32'(cnt), 32'h0);
        @(posedge clk);
        #1;
        set_req(0, 2'b00, 16'h00FF, 16'h0F0F);
        set_req(2, 2'b11, 16'h00FF, 16'h0F0F);
        wait_grant(0, "post_rst");
        finish_op(0, 16'h000F, "post_rst");
        wait_grant(2, "post_rst2");
        finish_op(2, 16'hF000, "post_rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
